// File: rtl/rv_mc_sequencer.sv
// Multicycle control sequencer for the bus-based RV32I datapath: decoded control
// fields, one encoded bus driver per cycle, memory handshake with timeout, trap and instret.
module rv_mc_sequencer #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             mem_ready,
    input  logic             br_taken,
    output logic [2:0]       bus_sel,
    output logic [2:0]       imm_sel,
    output logic             pc_en,
    output logic             a_en,
    output logic             b_en,
    output logic             ir_en,
    output logic             wd_en,
    output logic             rf_ren,
    output logic             rf_wen,
    output logic [1:0]       rf_addr_sel,
    output logic [3:0]       alu_op,
    output logic             alu_cmp,
    output logic             ram_ren,
    output logic             ram_wen,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret,
    output logic [4:0]       state_dbg
);

    localparam logic [4:0] S_F0    = 5'd0;
    localparam logic [4:0] S_F1    = 5'd1;
    localparam logic [4:0] S_DEC   = 5'd2;
    localparam logic [4:0] S_INC   = 5'd3;
    localparam logic [4:0] S_RS1   = 5'd4;
    localparam logic [4:0] S_RS2   = 5'd5;
    localparam logic [4:0] S_IMB   = 5'd6;
    localparam logic [4:0] S_EX    = 5'd7;
    localparam logic [4:0] S_LA    = 5'd8;
    localparam logic [4:0] S_LWAIT = 5'd9;
    localparam logic [4:0] S_SD    = 5'd10;
    localparam logic [4:0] S_SA    = 5'd11;
    localparam logic [4:0] S_BT0   = 5'd12;
    localparam logic [4:0] S_BT1   = 5'd13;
    localparam logic [4:0] S_BRS1  = 5'd14;
    localparam logic [4:0] S_BRS2  = 5'd15;
    localparam logic [4:0] S_BC    = 5'd16;
    localparam logic [4:0] S_BJ    = 5'd17;
    localparam logic [4:0] S_J0    = 5'd18;
    localparam logic [4:0] S_J1    = 5'd19;
    localparam logic [4:0] S_J2    = 5'd20;
    localparam logic [4:0] S_AU    = 5'd21;
    localparam logic [4:0] S_LU    = 5'd22;
    localparam logic [4:0] S_RET   = 5'd23;
    localparam logic [4:0] S_TRAP  = 5'd24;

    localparam logic [2:0] BUS_NONE  = 3'd0;
    localparam logic [2:0] BUS_PC    = 3'd1;
    localparam logic [2:0] BUS_ALU   = 3'd2;
    localparam logic [2:0] BUS_IMM   = 3'd3;
    localparam logic [2:0] BUS_RF    = 3'd4;
    localparam logic [2:0] BUS_RDATA = 3'd5;
    localparam logic [2:0] BUS_WD    = 3'd6;

    localparam logic [2:0] IMM_I  = 3'd0;
    localparam logic [2:0] IMM_S  = 3'd1;
    localparam logic [2:0] IMM_B  = 3'd2;
    localparam logic [2:0] IMM_U  = 3'd3;
    localparam logic [2:0] IMM_J  = 3'd4;
    localparam logic [2:0] IMM_C4 = 3'd5;

    localparam logic [1:0] RA_X0  = 2'd0;
    localparam logic [1:0] RA_RD  = 2'd1;
    localparam logic [1:0] RA_RS1 = 2'd2;
    localparam logic [1:0] RA_RS2 = 2'd3;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic [4:0]      state;
    logic [4:0]      state_nx;
    logic [1:0]      cause_nx;
    logic [TO_W-1:0] to_cnt;
    logic            waiting;
    logic            to_hit;
    logic [3:0]      alu_op_ex;

    logic is_r, is_i, is_lw, is_sw, is_br, is_jal, is_jalr, is_lui, is_auipc;

    assign is_r     = (opcode == OP_R);
    assign is_i     = (opcode == OP_I);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_br    = (opcode == OP_BR);
    assign is_jal   = (opcode == OP_JAL);
    assign is_jalr  = (opcode == OP_JALR);
    assign is_lui   = (opcode == OP_LUI);
    assign is_auipc = (opcode == OP_AUIPC);

    // funct7b5 only qualifies the I-type shifts (SRAI vs SRLI); elsewhere it is immediate bits.
    assign alu_op_ex = is_r ? {funct7b5, funct3}
                            : {(funct3 == 3'b101) & funct7b5, funct3};

    assign waiting = ((state == S_F1) || (state == S_LWAIT) || (state == S_SA)) && !mem_ready;
    assign to_hit  = (MEM_TIMEOUT != 0) && waiting && (to_cnt == TO_W'(MEM_TIMEOUT));

    assign state_dbg = state;

    always_comb begin
        state_nx = state;
        cause_nx = 2'd0;
        case (state)
            S_F0:  state_nx = S_F1;
            S_F1: begin
                if (mem_ready) begin
                    state_nx = S_DEC;
                end else if (to_hit) begin
                    state_nx = S_TRAP;
                    cause_nx = CAUSE_TIMEOUT;
                end
            end
            S_DEC: state_nx = S_INC;
            S_INC: begin
                if (is_r || is_i || is_lw || is_sw || is_jalr) begin
                    state_nx = S_RS1;
                end else if (is_br) begin
                    state_nx = S_BT0;
                end else if (is_jal || is_auipc) begin
                    state_nx = S_J0;
                end else if (is_lui) begin
                    state_nx = S_LU;
                end else begin
                    state_nx = S_TRAP;
                    cause_nx = CAUSE_ILLEGAL;
                end
            end
            S_RS1: state_nx = is_r ? S_RS2 : S_IMB;
            S_RS2: state_nx = S_EX;
            S_IMB: begin
                if (is_lw)        state_nx = S_LA;
                else if (is_sw)   state_nx = S_SD;
                else if (is_jalr) state_nx = S_J1;
                else              state_nx = S_EX;
            end
            S_EX:  state_nx = S_RET;
            S_LA:  state_nx = S_LWAIT;
            S_LWAIT, S_SA: begin
                if (mem_ready) begin
                    state_nx = S_RET;
                end else if (to_hit) begin
                    state_nx = S_TRAP;
                    cause_nx = CAUSE_TIMEOUT;
                end
            end
            S_SD:   state_nx = S_SA;
            S_BT0:  state_nx = S_BT1;
            S_BT1:  state_nx = S_BRS1;
            S_BRS1: state_nx = S_BRS2;
            S_BRS2: state_nx = S_BC;
            S_BC:   state_nx = br_taken ? S_BJ : S_RET;
            S_BJ:   state_nx = S_RET;
            S_J0:   state_nx = is_auipc ? S_AU : S_J1;
            S_J1:   state_nx = S_J2;
            S_J2:   state_nx = S_RET;
            S_AU:   state_nx = S_RET;
            S_LU:   state_nx = S_RET;
            S_RET:  state_nx = S_F0;
            S_TRAP: state_nx = S_TRAP;
            default: state_nx = S_F0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_F0;
            to_cnt     <= '0;
            trap_cause <= 2'd0;
            instret    <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state) begin
                to_cnt <= '0;
            end else if (waiting && (to_cnt != '1)) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if ((state_nx == S_TRAP) && (state != S_TRAP)) begin
                trap_cause <= cause_nx;
            end
            if (state == S_RET) begin
                instret <= instret + 1'b1;
            end
        end
    end

    // Outputs are forced low while rst is high so RAM strobes drop in the reset cycle itself.
    always_comb begin
        bus_sel     = BUS_NONE;
        imm_sel     = IMM_I;
        pc_en       = 1'b0;
        a_en        = 1'b0;
        b_en        = 1'b0;
        ir_en       = 1'b0;
        wd_en       = 1'b0;
        rf_ren      = 1'b0;
        rf_wen      = 1'b0;
        rf_addr_sel = RA_X0;
        alu_op      = 4'd0;
        alu_cmp     = 1'b0;
        ram_ren     = 1'b0;
        ram_wen     = 1'b0;
        trap        = 1'b0;
        if (!rst) begin
            case (state)
                S_F0: begin
                    bus_sel = BUS_PC;
                    ram_ren = 1'b1;
                    a_en    = 1'b1;
                end
                S_F1: begin
                    ram_ren = 1'b1;
                    if (mem_ready) begin
                        bus_sel = BUS_RDATA;
                        ir_en   = 1'b1;
                    end
                end
                S_DEC: begin
                    imm_sel = IMM_C4;
                    bus_sel = BUS_IMM;
                    b_en    = 1'b1;
                end
                S_INC: begin
                    bus_sel = BUS_ALU;
                    pc_en   = 1'b1;
                    wd_en   = 1'b1;
                end
                S_RS1, S_BRS1: begin
                    rf_addr_sel = RA_RS1;
                    rf_ren      = 1'b1;
                    bus_sel     = BUS_RF;
                    a_en        = 1'b1;
                end
                S_RS2, S_BRS2: begin
                    rf_addr_sel = RA_RS2;
                    rf_ren      = 1'b1;
                    bus_sel     = BUS_RF;
                    b_en        = 1'b1;
                end
                S_IMB: begin
                    imm_sel = is_sw ? IMM_S : IMM_I;
                    bus_sel = BUS_IMM;
                    b_en    = 1'b1;
                end
                S_EX: begin
                    alu_op      = alu_op_ex;
                    bus_sel     = BUS_ALU;
                    rf_addr_sel = RA_RD;
                    rf_wen      = 1'b1;
                end
                S_LA: begin
                    bus_sel = BUS_ALU;
                    ram_ren = 1'b1;
                end
                S_LWAIT: begin
                    ram_ren = 1'b1;
                    if (mem_ready) begin
                        bus_sel     = BUS_RDATA;
                        rf_addr_sel = RA_RD;
                        rf_wen      = 1'b1;
                    end
                end
                S_SD: begin
                    rf_addr_sel = RA_RS2;
                    rf_ren      = 1'b1;
                    bus_sel     = BUS_RF;
                    wd_en       = 1'b1;
                end
                S_SA: begin
                    bus_sel = BUS_ALU;
                    ram_wen = 1'b1;
                end
                S_BT0: begin
                    imm_sel = IMM_B;
                    bus_sel = BUS_IMM;
                    b_en    = 1'b1;
                end
                S_BT1: begin
                    bus_sel = BUS_ALU;
                    wd_en   = 1'b1;
                end
                S_BC:  alu_cmp = 1'b1;
                S_BJ: begin
                    bus_sel = BUS_WD;
                    pc_en   = 1'b1;
                end
                S_J0: begin
                    imm_sel = is_auipc ? IMM_U : IMM_J;
                    bus_sel = BUS_IMM;
                    b_en    = 1'b1;
                end
                S_AU: begin
                    bus_sel     = BUS_ALU;
                    rf_addr_sel = RA_RD;
                    rf_wen      = 1'b1;
                end
                // Link (oldPC+4 held in WD) is written before the PC moves, so rd==rs1 is safe.
                S_J1: begin
                    bus_sel     = BUS_WD;
                    rf_addr_sel = RA_RD;
                    rf_wen      = 1'b1;
                end
                S_J2: begin
                    bus_sel = BUS_ALU;
                    alu_op  = is_jalr ? 4'b1111 : 4'b0000;
                    pc_en   = 1'b1;
                end
                S_LU: begin
                    imm_sel     = IMM_U;
                    bus_sel     = BUS_IMM;
                    rf_addr_sel = RA_RD;
                    rf_wen      = 1'b1;
                end
                S_TRAP: trap = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_mc_sequencer.sv
// Scoreboard bench for rv_mc_sequencer: expected pc/rf write events are queued per
// instruction and popped as the sequencer produces them.
module tb_rv_mc_sequencer;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             funct7b5;
    logic             mem_ready;
    logic             br_taken;
    logic [2:0]       bus_sel;
    logic [2:0]       imm_sel;
    logic             pc_en, a_en, b_en, ir_en, wd_en;
    logic             rf_ren, rf_wen;
    logic [1:0]       rf_addr_sel;
    logic [3:0]       alu_op;
    logic             alu_cmp;
    logic             ram_ren, ram_wen;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] instret;
    logic [4:0]       state_dbg;

    int total = 0;
    int bad   = 0;
    int exp_ir = 0;
    logic [15:0] sb[$];

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [1:0] EV_PC = 2'd1;
    localparam logic [1:0] EV_RF = 2'd2;

    rv_mc_sequencer #(.CNT_W(CNT_W), .MEM_TIMEOUT(16), .TO_W(5)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .mem_ready(mem_ready), .br_taken(br_taken), .bus_sel(bus_sel), .imm_sel(imm_sel),
        .pc_en(pc_en), .a_en(a_en), .b_en(b_en), .ir_en(ir_en), .wd_en(wd_en),
        .rf_ren(rf_ren), .rf_wen(rf_wen), .rf_addr_sel(rf_addr_sel), .alu_op(alu_op),
        .alu_cmp(alu_cmp), .ram_ren(ram_ren), .ram_wen(ram_wen), .trap(trap),
        .trap_cause(trap_cause), .instret(instret), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ev(input logic [1:0] k, input logic [2:0] bs,
                                       input logic [1:0] ad, input logic [3:0] op);
        return {2'b00, k, 1'b0, bs, 2'b00, ad, op};
    endfunction

    task automatic pop_chk(input string tag, input logic [15:0] got);
        if (sb.size() == 0) check_eq({tag, ".extra_ev"}, got, 16'hdead);
        else check_eq({tag, ".ev"}, got, sb.pop_front());
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        exp_ir = 0;
    endtask

    // Memory model: mem_ready after (base + latency) strobe cycles; base covers the request cycle for reads.
    task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic br, input int flat, input int lat,
                             input int exp_cyc, input int exp_rr, input int exp_wr);
        int cyc, mcnt, nrr, nwr;
        bit fetched;
        opcode = op; funct3 = f3; funct7b5 = f7; br_taken = br;
        cyc = 0; mcnt = 0; nrr = 0; nwr = 0; fetched = 0;
        forever begin
            if (ram_ren || ram_wen) mcnt++; else mcnt = 0;
            mem_ready = (ram_ren || ram_wen) &&
                        (mcnt >= (ram_wen ? 1 : 2) + (fetched ? lat : flat));
            #1;
            if (fetched && ram_ren) nrr++;
            if (ram_wen) nwr++;
            if (pc_en)  pop_chk(tag, ev(EV_PC, bus_sel, rf_addr_sel, alu_op));
            if (rf_wen) pop_chk(tag, ev(EV_RF, bus_sel, rf_addr_sel, alu_op));
            if (ir_en) fetched = 1;
            cyc++;
            @(negedge clk);
            if (state_dbg == 5'd0 || trap || cyc >= 200) break;
        end
        mem_ready = 1'b0;
        check_eq({tag, ".cycles"}, cyc, exp_cyc);
        check_eq({tag, ".sb_left"}, sb.size(), 0);
        check_eq({tag, ".ram_ren_n"}, nrr, exp_rr);
        check_eq({tag, ".ram_wen_n"}, nwr, exp_wr);
        sb.delete();
    endtask

    task automatic retire_chk(input string tag);
        exp_ir++;
        check_eq({tag, ".instret"}, instret, exp_ir);
    endtask

    initial begin
        int mcnt, nrr;
        bit fetched;
        opcode = OP_R; funct3 = 3'd0; funct7b5 = 1'b0; br_taken = 1'b0;
        rst = 1'b1; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst.state", state_dbg, 0);
        check_eq("rst.bus", bus_sel, 0);
        check_eq("rst.ram_ren", ram_ren, 0);
        check_eq("rst.trap", {trap, trap_cause}, 0);
        check_eq("rst.instret", instret, 0);
        rst = 1'b0;
        #1;
        check_eq("f0.bus_pc", {bus_sel, ram_ren, a_en}, {3'd1, 1'b1, 1'b1});

        sb.push_back(ev(EV_PC, 3'd2, 2'd0, 4'd0));
        sb.push_back(ev(EV_RF, 3'd2, 2'd1, 4'b0000));
        run_instr("add", OP_R, 3'b000, 1'b0, 1'b0, 0, 0, 8, 0, 0);
        retire_chk("add");

        sb.push_back(ev(EV_PC, 3'd2, 2'd0, 4'd0));
        sb.push_back(ev(EV_RF, 3'd2, 2'd1, 4'b1000));
        run_instr("sub", OP_R, 3'b000, 1'b1, 1'b0, 0, 0, 8, 0, 0);
        retire_chk("sub");

        sb.push_back(ev(EV_PC, 3'd2, 2'd0, 4'd0));
        sb.push_back(ev(EV_RF, 3'd2, 2'd1, 4'b1101));
        run_instr("srai", OP_I, 3'b101, 1'b1, 1'b0, 0, 0, 8, 0, 0);
        retire_chk("srai");

        sb.push_back(ev(EV_PC, 3'd2, 2'd0, 4'd0));
        sb.push_back(ev(EV_RF, 3'd2, 2'd1, 4'b0000));
        run_instr("addi_b30", OP_I, 3'b000, 1'b1, 1'b0, 0, 0, 8, 0, 0);
        retire_chk("addi_b30");

        sb.push_back(ev(EV_PC, 3'd2, 2'd0, 4'd0));
        sb.push_back(ev(EV_RF, 3'd5, 2'd1, 4'd0));
        run_instr("lw", OP_LW, 3'b010, 1'b0, 1'b0, 0, 2, 11, 4, 0);
        retire_chk("lw");

        sb.push_back(ev(EV_PC, 3'd2, 2'd0, 4'd0));
        run_instr("sw", OP_SW, 3'b010, 1'b0, 1'b0, 0, 3, 12, 0, 4);
        retire_chk("sw");

        sb.push_back(ev(EV_PC, 3'd2, 2'd0, 4'd0));
        sb.push_back(ev(EV_PC, 3'd6, 2'd0, 4'd0));
        run_instr("beq_t", OP_BR, 3'b000, 1'b0, 1'b1, 0, 0, 11, 0, 0);
        retire_chk("beq_t");

        sb.push_back(ev(EV_PC, 3'd2, 2'd0, 4'd0));
        run_instr("beq_nt", OP_BR, 3'b000, 1'b0, 1'b0, 0, 0, 10, 0, 0);
        retire_chk("beq_nt");

        sb.push_back(ev(EV_PC, 3'd2, 2'd0, 4'd0));
        sb.push_back(ev(EV_RF, 3'd6, 2'd1, 4'd0));
        sb.push_back(ev(EV_PC, 3'd2, 2'd0, 4'b1111));
        run_instr("jalr", OP_JALR, 3'b000, 1'b0, 1'b0, 0, 0, 9, 0, 0);
        retire_chk("jalr");

        sb.push_back(ev(EV_PC, 3'd2, 2'd0, 4'd0));
        sb.push_back(ev(EV_RF, 3'd6, 2'd1, 4'd0));
        sb.push_back(ev(EV_PC, 3'd2, 2'd0, 4'd0));
        run_instr("jal", OP_JAL, 3'b000, 1'b0, 1'b0, 0, 0, 8, 0, 0);
        retire_chk("jal");

        sb.push_back(ev(EV_PC, 3'd2, 2'd0, 4'd0));
        sb.push_back(ev(EV_RF, 3'd2, 2'd1, 4'd0));
        run_instr("auipc", OP_AUIPC, 3'b000, 1'b0, 1'b0, 0, 0, 7, 0, 0);
        retire_chk("auipc");

        sb.push_back(ev(EV_PC, 3'd2, 2'd0, 4'd0));
        sb.push_back(ev(EV_RF, 3'd3, 2'd1, 4'd0));
        run_instr("lui", OP_LUI, 3'b000, 1'b0, 1'b0, 0, 0, 6, 0, 0);
        retire_chk("lui");

        // mem_ready arrives exactly in the cycle the wait counter reaches the limit
        sb.push_back(ev(EV_PC, 3'd2, 2'd0, 4'd0));
        sb.push_back(ev(EV_RF, 3'd2, 2'd1, 4'd0));
        run_instr("ready_at_limit", OP_R, 3'b000, 1'b0, 1'b0, 16, 0, 24, 0, 0);
        retire_chk("ready_at_limit");
        check_eq("ready_at_limit.trap", trap, 0);

        // reset while a load waits in LWAIT
        opcode = OP_LW; funct3 = 3'b010; funct7b5 = 1'b0;
        mcnt = 0; nrr = 0; fetched = 0;
        for (int i = 0; i < 40; i++) begin
            if (ram_ren) mcnt++; else mcnt = 0;
            mem_ready = ram_ren && !fetched && (mcnt >= 2);
            #1;
            if (fetched && ram_ren) nrr++;
            if (ir_en) fetched = 1;
            if (nrr == 2) break;
            @(negedge clk);
        end
        check_eq("rst_lwait.reached", nrr, 2);
        rst = 1'b1;
        mem_ready = 1'b0;
        #1;
        check_eq("rst_lwait.ren_now", ram_ren, 0);
        @(negedge clk);
        check_eq("rst_lwait.state", state_dbg, 0);
        check_eq("rst_lwait.ren_next", ram_ren, 0);
        check_eq("rst_lwait.instret", instret, 0);
        rst = 1'b0;
        #1;
        exp_ir = 0;

        // fetch never completes
        run_instr("timeout", OP_R, 3'b000, 1'b0, 1'b0, 1000, 0, 18, 0, 0);
        check_eq("timeout.trap", trap, 1);
        check_eq("timeout.cause", trap_cause, 2);
        do_reset();

        sb.push_back(ev(EV_PC, 3'd2, 2'd0, 4'd0));
        run_instr("illegal", 7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, 4, 0, 0);
        check_eq("illegal.trap", trap, 1);
        check_eq("illegal.cause", trap_cause, 1);
        for (int i = 0; i < 20; i++) begin
            check_eq("illegal.quiet",
                     {trap, bus_sel, pc_en, a_en, b_en, ir_en, wd_en, rf_ren, rf_wen, ram_ren, ram_wen},
                     {1'b1, 3'd0, 9'd0});
            @(negedge clk);
        end
        check_eq("illegal.instret", instret, 0);
        do_reset();
        check_eq("post_trap.state", state_dbg, 0);
        check_eq("post_trap.flags", {trap, trap_cause, instret}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
